// File: rtl/updw_sweep_ctrl.sv
// Triangle-sweep sequencer: counts 0 -> UPBND -> 0 a programmable number of
// times, with start, pause, abort and a one-cycle completion pulse.
module updw_sweep_ctrl #(
  parameter  int UPBND   = 11,
  parameter  int BW_NSWP = 4,
  localparam int CW      = $clog2(UPBND + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [BW_NSWP-1:0] i_nsweep,
  input  logic               i_pause,
  input  logic               i_abort,
  output logic [CW-1:0]      o_cnt,
  output logic               o_mode,
  output logic               o_busy,
  output logic               o_done,
  output logic [BW_NSWP-1:0] o_sweep
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] PEAK = CW'(UPBND);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [BW_NSWP-1:0] sweep_q, sweep_d;
  logic [BW_NSWP-1:0] nsw_q, nsw_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sweep_q <= '0;
      nsw_q   <= '0;
      mode_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sweep_q <= sweep_d;
      nsw_q   <= nsw_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sweep_d = sweep_q;
    nsw_d   = nsw_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (i_start && (i_nsweep != '0)) begin
          nsw_d   = i_nsweep;
          sweep_d = '0;
          state_d = S_UP;
        end
      end
      S_UP: begin
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!i_pause) begin
          if (cnt_q == PEAK) begin
            cnt_d   = PEAK - ONE;
            state_d = S_DOWN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_DOWN: begin
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!i_pause) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else begin
            // Next sweep restarts at 1 so the valley value is not repeated
            sweep_d = sweep_q + 1'b1;
            if (sweep_d == nsw_q) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end else begin
              state_d = S_UP;
              cnt_d   = ONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    mode_d = (state_d != S_DOWN);
    busy_d = (state_d == S_UP) || (state_d == S_DOWN);
    done_d = (state_d == S_DONE);
  end

  assign o_cnt   = cnt_q;
  assign o_mode  = mode_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_sweep = sweep_q;

endmodule

// File: tb/tb_updw_sweep_ctrl.sv
// Directed bench for updw_sweep_ctrl with hand-computed expectations.
module tb_updw_sweep_ctrl;

  localparam int UPBND = 11;
  localparam int BW    = 4;
  localparam int CW    = $clog2(UPBND + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] nsweep = '0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] cnt;
  logic          mode;
  logic          busy;
  logic          done;
  logic [BW-1:0] sweep;

  int n_chk = 0;
  int n_err = 0;
  int edges = 0;

  updw_sweep_ctrl #(.UPBND(UPBND), .BW_NSWP(BW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_nsweep(nsweep),
    .i_pause (pause),
    .i_abort (abort),
    .o_cnt   (cnt),
    .o_mode  (mode),
    .o_busy  (busy),
    .o_done  (done),
    .o_sweep (sweep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic outs(input string tag, input int c, input int m,
                      input int b, input int d, input int s);
    chk({tag, ".cnt"},   int'(cnt),   c);
    chk({tag, ".mode"},  int'(mode),  m);
    chk({tag, ".busy"},  int'(busy),  b);
    chk({tag, ".done"},  int'(done),  d);
    chk({tag, ".sweep"}, int'(sweep), s);
  endtask

  // One triangle after the UP-entry value: 1..UPBND then UPBND-1..0
  task automatic tri_seq(input string tag);
    for (int k = 1; k <= UPBND; k++) begin
      tick();
      chk({tag, ".up"}, int'(cnt), k);
      chk({tag, ".upm"}, int'(mode), 1);
      chk({tag, ".upd"}, int'(done), 0);
    end
    for (int k = UPBND - 1; k >= 0; k--) begin
      tick();
      chk({tag, ".dn"}, int'(cnt), k);
      chk({tag, ".dnm"}, int'(mode), 0);
      chk({tag, ".dnd"}, int'(done), 0);
    end
  endtask

  task automatic do_start(input int n);
    start  = 1'b1;
    nsweep = BW'(n);
    tick();
    edges  = 1;
    start  = 1'b0;
  endtask

  initial begin
    // reset
    repeat (4) tick();
    outs("rst", 0, 1, 0, 0, 0);
    rst = 1'b0;
    tick();
    outs("idle", 0, 1, 0, 0, 0);

    // single sweep
    do_start(1);
    outs("s1.start", 0, 1, 1, 0, 0);
    tri_seq("s1");
    tick();
    chk("s1.edges", edges, 24);
    outs("s1.done", 0, 1, 0, 1, 1);
    tick();
    outs("s1.idle", 0, 1, 0, 0, 1);

    // two sweeps, start held and nsweep changed while busy
    do_start(2);
    start  = 1'b1;
    nsweep = 4'd7;
    tri_seq("s2a");
    chk("s2a.sweep", int'(sweep), 0);
    tri_seq("s2b");
    tick();
    chk("s2.edges", edges, 46);
    outs("s2.done", 0, 1, 0, 1, 2);
    tick();
    outs("s2.idle", 0, 1, 0, 0, 2);
    tick();
    outs("s2.restart", 0, 1, 1, 0, 0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outs("s2.abort", 0, 1, 0, 0, 0);

    // pause at cnt=7 in DOWN
    do_start(1);
    repeat (UPBND + 4) tick();
    outs("p.at7", 7, 0, 1, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      outs("p.hold", 7, 0, 1, 0, 0);
    end
    pause = 1'b0;
    tick();
    outs("p.resume", 6, 0, 1, 0, 0);
    repeat (6) tick();
    chk("p.zero", int'(cnt), 0);
    chk("p.nodone", int'(done), 0);
    tick();
    chk("p.edges", edges, 29);
    outs("p.done", 0, 1, 0, 1, 1);
    tick();

    // abort in second sweep at cnt=4 UP
    do_start(2);
    tri_seq("a1");
    repeat (4) tick();
    outs("a.at4", 4, 1, 1, 0, 1);
    abort = 1'b1;
    pause = 1'b1;
    tick();
    abort = 1'b0;
    pause = 1'b0;
    outs("a.idle", 0, 1, 0, 0, 1);
    // zero-length start is ignored
    start  = 1'b1;
    nsweep = '0;
    tick();
    outs("z.ign", 0, 1, 0, 0, 1);
    nsweep = 4'd1;
    tick();
    start = 1'b0;
    outs("a.restart", 0, 1, 1, 0, 0);
    tri_seq("a2");
    tick();
    outs("a2.done", 0, 1, 0, 1, 1);
    tick();

    // async reset in second sweep at cnt=9
    do_start(3);
    tri_seq("r1");
    repeat (9) tick();
    outs("r.at9", 9, 1, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    outs("r.async", 0, 1, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    outs("r.idle", 0, 1, 0, 0, 0);
    do_start(1);
    tri_seq("r2");
    tick();
    chk("r2.edges", edges, 24);
    outs("r2.done", 0, 1, 0, 1, 1);
    tick();
    outs("r2.idle", 0, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/updw_sweep_ctrl.md
Name: updw_sweep_ctrl

Overview:
- Sequencer that runs a bounded up/down count as a programmable number of triangle sweeps: 0 -> UPBND -> 0, repeated N times.
- Owns the count register and the direction/mode signal, and adds start, pause, abort and completion handshakes.
- Sits between a control/CSR front end and any logic that consumes an up/down count value and direction flag.

Parameters:
- UPBND, 11, peak count value; legal range >= 1.
- BW_NSWP, 4, bit width of the sweep-count request and the progress counter.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; sampled only in IDLE.
- i_nsweep  input  BW_NSWP  number of full sweeps to run; latched when a start is accepted.
- i_pause  input  1  level; freezes all state while high in UP or DOWN.
- i_abort  input  1  level; terminates the run early.
- o_cnt  output  $clog2(UPBND+1)  current count.
- o_mode  output  1  direction: 1 = up, 0 = down.
- o_busy  output  1  high in the UP and DOWN states.
- o_done  output  1  one-cycle completion pulse.
- o_sweep  output  BW_NSWP  number of completed sweeps.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - state=IDLE, o_cnt=0, o_mode=1, o_busy=0, o_done=0, o_sweep=0, latched nsweep=0.
- States: IDLE, UP, DOWN, DONE. Outputs are registered; o_mode=0 only in DOWN.
- IDLE:
  - o_cnt held at 0.
  - If i_start=1 and i_nsweep!=0 at an edge: latch i_nsweep, clear o_sweep, next state UP with o_cnt=0.
  - A start with i_nsweep=0 is ignored and nothing changes.
- UP, no pause/abort:
  - If o_cnt<UPBND: o_cnt+1.
  - If o_cnt==UPBND: o_cnt becomes UPBND-1 and state becomes DOWN. The peak value is visible for exactly one cycle.
- DOWN, no pause/abort:
  - If o_cnt>0: o_cnt-1.
  - If o_cnt==0: o_sweep+1 (no wrap; it cannot exceed the latched nsweep).
  - At that o_cnt==0 edge, if the new o_sweep equals the latched nsweep: state becomes DONE and o_cnt stays 0.
  - Otherwise state becomes UP with o_cnt=1. There is no repeated 0 between sweeps.
- DONE:
  - Lasts exactly one cycle; o_done=1, o_busy=0, o_cnt=0; then IDLE.
  - i_start, i_pause and i_abort are ignored in DONE.
- Timing: the first sweep occupies 2*UPBND+1 edges from UP entry to the DOWN-exit edge; each later sweep occupies 2*UPBND edges.
- Pause (i_pause=1 in UP/DOWN): state, o_cnt, o_mode and o_sweep hold. o_busy stays 1.
- Abort (i_abort=1 in UP/DOWN):
  - Next edge: IDLE, o_cnt=0, o_mode=1, no o_done pulse.
  - o_sweep keeps its value so software can read progress.
  - Abort has priority over pause and over the DOWN-to-DONE transition.
- i_start is ignored outside IDLE. i_nsweep changes after acceptance have no effect.
- Reset asserted mid-run returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan:
- UPBND=11, reset 4 cycles, start with nsweep=1:
  - o_cnt goes 0..11 then 10..0; o_mode falls on the edge after cnt=11.
  - o_done high one cycle, 24 edges after the start edge; o_sweep=1; o_busy low afterwards.
- nsweep=2:
  - Sequence 0..11..0,1..11..0 with no duplicate 0 between sweeps.
  - o_sweep goes 1 then 2; a single o_done pulse at edge 46 after start.
- Pause for 5 cycles at o_cnt=7 in DOWN:
  - o_cnt holds 7, o_mode holds 0, o_busy holds 1.
  - On resume the count continues to 6; completion is delayed by exactly 5 cycles.
- Abort during the second sweep at o_cnt=4 in UP:
  - Next edge: IDLE, o_cnt=0, o_mode=1, o_sweep=1, o_done never asserted.
  - A new start is accepted 1 cycle later.
- Start with nsweep=0, and start pulses while busy:
  - Both are ignored, with no state or o_sweep change.
  - i_start held high through DONE is ignored; a new run begins only from the first IDLE cycle after DONE.
- Assert i_rst asynchronously (between edges) mid-sweep at o_cnt=9:
  - All outputs reach reset values before the next clock edge.
  - After release, a normal start completes correctly.
